// File: rtl/hazard_ctrl.sv
// Hazard and interrupt-entry control: load-use stalls, branch flushes,
// and the drain / EPC capture / vector-jump sequence.
module hazard_ctrl #(
    parameter logic [3:0]  NO_REG       = 4'hF,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [15:0] VECTOR_ADDR  = 16'h0008
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        idex_memread_i,
    input  logic [3:0]  idex_regdst_i,
    input  logic [3:0]  id_regsrc1_i,
    input  logic [3:0]  id_regsrc2_i,
    input  logic [3:0]  id_regsrc_sw_i,
    input  logic [15:0] id_pc_i,
    input  logic        ex_branch_i,
    input  logic [15:0] ex_target_i,
    input  logic        irq_i,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        stall_LW_o,
    output logic [1:0]  pc_sel_o,
    output logic [15:0] pc_target_o,
    output logic [15:0] epc_o,
    output logic        irq_busy_o
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        JUMP
    } state_t;

    state_t      state, state_n;
    logic        pend, pend_n;
    logic [3:0]  cnt, cnt_n;
    logic [15:0] epc_n;
    logic        lu;
    logic        enter;

    assign lu = idex_memread_i
              & (idex_regdst_i != NO_REG)
              & ((idex_regdst_i == id_regsrc1_i)
               | (idex_regdst_i == id_regsrc2_i)
               | (idex_regdst_i == id_regsrc_sw_i));

    // Entering DRAIN consumes the request; anything arriving later re-arms pend.
    assign pend_n = enter ? 1'b0 : (pend | irq_i);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= RUN;
            pend  <= 1'b0;
            cnt   <= 4'd0;
            epc_o <= 16'h0000;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            cnt   <= cnt_n;
            epc_o <= epc_n;
        end
    end

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        epc_n        = epc_o;
        enter        = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        flush_if_o   = 1'b0;
        flush_id_o   = 1'b0;
        stall_LW_o   = 1'b0;
        pc_sel_o     = 2'd0;
        pc_target_o  = 16'h0000;
        irq_busy_o   = 1'b0;
        unique case (state)
            RUN: begin
                if (ex_branch_i) begin
                    pc_sel_o    = 2'd1;
                    pc_target_o = ex_target_i;
                    flush_if_o  = 1'b1;
                    flush_id_o  = 1'b1;
                end else if (lu) begin
                    stall_LW_o   = 1'b1;
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    flush_id_o   = 1'b1;
                end else if (pend | irq_i) begin
                    enter        = 1'b1;
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    flush_if_o   = 1'b1;
                    epc_n        = id_pc_i;
                    cnt_n        = 4'(DRAIN_CYCLES - 1);
                    state_n      = DRAIN;
                end
            end
            // Branches seen here are older than EPC and already redirected.
            DRAIN: begin
                pc_write_o   = 1'b0;
                ifid_write_o = 1'b0;
                flush_if_o   = 1'b1;
                flush_id_o   = 1'b1;
                irq_busy_o   = 1'b1;
                if (cnt == 4'd0) begin
                    state_n = JUMP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            JUMP: begin
                pc_sel_o    = 2'd2;
                pc_target_o = VECTOR_ADDR;
                pc_write_o  = 1'b1;
                flush_if_o  = 1'b1;
                irq_busy_o  = 1'b1;
                state_n     = RUN;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, flushes and interrupt entry.
module tb_hazard_ctrl;

    logic        CLK;
    logic        RST;
    logic        idex_memread_i;
    logic [3:0]  idex_regdst_i;
    logic [3:0]  id_regsrc1_i;
    logic [3:0]  id_regsrc2_i;
    logic [3:0]  id_regsrc_sw_i;
    logic [15:0] id_pc_i;
    logic        ex_branch_i;
    logic [15:0] ex_target_i;
    logic        irq_i;
    logic        pc_write_o;
    logic        ifid_write_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        stall_LW_o;
    logic [1:0]  pc_sel_o;
    logic [15:0] pc_target_o;
    logic [15:0] epc_o;
    logic        irq_busy_o;

    int checks = 0;
    int errors = 0;

    // {pc_write, ifid_write, flush_if, flush_id, stall_LW, pc_sel[1:0], irq_busy}
    logic [7:0] ctl;
    assign ctl = {pc_write_o, ifid_write_o, flush_if_o, flush_id_o,
                  stall_LW_o, pc_sel_o, irq_busy_o};

    localparam logic [7:0] C_IDLE   = 8'b1100_0000;
    localparam logic [7:0] C_STALL  = 8'b0001_1000;
    localparam logic [7:0] C_BRANCH = 8'b1111_0010;
    localparam logic [7:0] C_ENTER  = 8'b0010_0000;
    localparam logic [7:0] C_DRAIN  = 8'b0011_0001;
    // JUMP: ifid_write is masked out of the comparison
    localparam logic [7:0] C_JUMP   = 8'b1010_0101;
    localparam logic [7:0] M_JUMP   = 8'b1011_1111;

    hazard_ctrl dut (
        .CLK            (CLK),
        .RST            (RST),
        .idex_memread_i (idex_memread_i),
        .idex_regdst_i  (idex_regdst_i),
        .id_regsrc1_i   (id_regsrc1_i),
        .id_regsrc2_i   (id_regsrc2_i),
        .id_regsrc_sw_i (id_regsrc_sw_i),
        .id_pc_i        (id_pc_i),
        .ex_branch_i    (ex_branch_i),
        .ex_target_i    (ex_target_i),
        .irq_i          (irq_i),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .flush_if_o     (flush_if_o),
        .flush_id_o     (flush_id_o),
        .stall_LW_o     (stall_LW_o),
        .pc_sel_o       (pc_sel_o),
        .pc_target_o    (pc_target_o),
        .epc_o          (epc_o),
        .irq_busy_o     (irq_busy_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        idex_memread_i = 1'b0;
        idex_regdst_i  = 4'hF;
        id_regsrc1_i   = 4'hF;
        id_regsrc2_i   = 4'hF;
        id_regsrc_sw_i = 4'hF;
        id_pc_i        = 16'h0000;
        ex_branch_i    = 1'b0;
        ex_target_i    = 16'h0000;
        irq_i          = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle();
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_ctl got %b want %b", ctl, C_IDLE);
        end
        checks++;
        if (epc_o !== 16'h0000) begin
            errors++;
            $display("FAIL reset_epc got %h want 0000", epc_o);
        end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL run_idle got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_load_use();
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd3;
        id_regsrc1_i   = 4'd5;
        id_regsrc2_i   = 4'd3;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL lu_src2 got %b want %b", ctl, C_STALL);
        end
        @(negedge CLK);
        idex_memread_i = 1'b0;
        idex_regdst_i  = 4'hF;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL lu_release got %b want %b", ctl, C_IDLE);
        end
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd7;
        id_regsrc_sw_i = 4'd7;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL lu_sw got %b want %b", ctl, C_STALL);
        end
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd2;
        id_regsrc1_i   = 4'd2;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL lu_src1 got %b want %b", ctl, C_STALL);
        end
    endtask

    task automatic test_no_stall();
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'hF;
        id_regsrc1_i   = 4'hF;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL no_reg got %b want %b", ctl, C_IDLE);
        end
        @(negedge CLK);
        idle();
        idex_regdst_i = 4'd3;
        id_regsrc1_i  = 4'd3;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL not_load got %b want %b", ctl, C_IDLE);
        end
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd4;
        id_regsrc1_i   = 4'd5;
        id_regsrc2_i   = 4'd6;
        id_regsrc_sw_i = 4'd1;
        #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL no_match got %b want %b", ctl, C_IDLE);
        end
    endtask

    task automatic test_branch();
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd3;
        id_regsrc2_i   = 4'd3;
        ex_branch_i    = 1'b1;
        ex_target_i    = 16'h0040;
        #1;
        checks++;
        if (ctl !== C_BRANCH) begin
            errors++;
            $display("FAIL branch_ctl got %b want %b", ctl, C_BRANCH);
        end
        checks++;
        if (pc_target_o !== 16'h0040) begin
            errors++;
            $display("FAIL branch_tgt got %h want 0040", pc_target_o);
        end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd1;
        id_regsrc1_i   = 4'd1;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL b2b_first got %b want %b", ctl, C_STALL);
        end
        @(negedge CLK);
        idex_regdst_i = 4'd2;
        id_regsrc2_i  = 4'd2;
        id_regsrc1_i  = 4'd0;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL b2b_second got %b want %b", ctl, C_STALL);
        end
        @(negedge CLK);
        idle();
    endtask

    task automatic test_irq();
        int busy;
        busy = 0;
        @(negedge CLK);
        idle();
        irq_i   = 1'b1;
        id_pc_i = 16'h0123;
        #1;
        checks++;
        if (ctl !== C_ENTER) begin
            errors++;
            $display("FAIL irq_enter got %b want %b", ctl, C_ENTER);
        end
        @(negedge CLK);
        irq_i   = 1'b0;
        id_pc_i = 16'h0124;
        #1;
        checks++;
        if (epc_o !== 16'h0123) begin
            errors++;
            $display("FAIL irq_epc got %h want 0123", epc_o);
        end
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge CLK);
            ex_branch_i = (i == 1);
            ex_target_i = 16'h0777;
            #1;
            if (irq_busy_o === 1'b1) busy++;
            checks++;
            if (ctl !== C_DRAIN) begin
                errors++;
                $display("FAIL irq_drain%0d got %b want %b", i, ctl, C_DRAIN);
            end
        end
        @(negedge CLK);
        ex_branch_i = 1'b0;
        #1;
        if (irq_busy_o === 1'b1) busy++;
        checks++;
        if ((ctl & M_JUMP) !== C_JUMP) begin
            errors++;
            $display("FAIL irq_jump got %b want %b", ctl & M_JUMP, C_JUMP);
        end
        checks++;
        if (pc_target_o !== 16'h0008) begin
            errors++;
            $display("FAIL irq_vec got %h want 0008", pc_target_o);
        end
        @(negedge CLK);
        #1;
        if (irq_busy_o === 1'b1) busy++;
        checks++;
        if (busy != 4 || ctl !== C_IDLE) begin
            errors++;
            $display("FAIL irq_return busy %0d ctl %b want 4 %b", busy, ctl, C_IDLE);
        end
        checks++;
        if (epc_o !== 16'h0123) begin
            errors++;
            $display("FAIL epc_hold got %h want 0123", epc_o);
        end
    endtask

    task automatic test_irq_during_stall();
        int n;
        @(negedge CLK);
        idle();
        idex_memread_i = 1'b1;
        idex_regdst_i  = 4'd3;
        id_regsrc2_i   = 4'd3;
        irq_i          = 1'b1;
        id_pc_i        = 16'h01FF;
        #1;
        checks++;
        if (ctl !== C_STALL) begin
            errors++;
            $display("FAIL t5_stall got %b want %b", ctl, C_STALL);
        end
        @(negedge CLK);
        idle();
        id_pc_i = 16'h0200;
        #1;
        checks++;
        if (ctl !== C_ENTER) begin
            errors++;
            $display("FAIL t5_enter got %b want %b", ctl, C_ENTER);
        end
        @(negedge CLK);
        id_pc_i = 16'h0201;
        irq_i   = 1'b1;
        #1;
        checks++;
        if (epc_o !== 16'h0200 || irq_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL t5_epc got %h busy %b want 0200 1", epc_o, irq_busy_o);
        end
        @(negedge CLK);
        irq_i   = 1'b0;
        id_pc_i = 16'h0300;
        n = 0;
        #1;
        while (irq_busy_o === 1'b1 && n < 10) begin
            @(negedge CLK);
            #1;
            n++;
        end
        checks++;
        if (ctl !== C_ENTER) begin
            errors++;
            $display("FAIL pend_reentry got %b want %b after %0d", ctl, C_ENTER, n);
        end
        @(negedge CLK);
        #1;
        checks++;
        if (epc_o !== 16'h0300) begin
            errors++;
            $display("FAIL pend_epc got %h want 0300", epc_o);
        end
        n = 0;
        while (irq_busy_o === 1'b1 && n < 10) begin
            @(negedge CLK);
            #1;
            n++;
        end
        checks++;
        if (irq_busy_o !== 1'b0) begin
            errors++;
            $display("FAIL pend_timeout busy %b want 0", irq_busy_o);
        end
    endtask

    task automatic test_reset_in_drain();
        int bad;
        bad = 0;
        @(negedge CLK);
        idle();
        irq_i   = 1'b1;
        id_pc_i = 16'h0456;
        @(negedge CLK);
        id_pc_i = 16'h0457;
        #1;
        checks++;
        if (irq_busy_o !== 1'b1 || epc_o !== 16'h0456) begin
            errors++;
            $display("FAIL t6_drain busy %b epc %h want 1 0456", irq_busy_o, epc_o);
        end
        @(negedge CLK);
        irq_i = 1'b0;
        RST   = 1'b0;
        #1;
        checks++;
        if (ctl !== C_IDLE || epc_o !== 16'h0000) begin
            errors++;
            $display("FAIL t6_reset ctl %b epc %h want %b 0000", ctl, epc_o, C_IDLE);
        end
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            #1;
            if (ctl !== C_IDLE) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL t6_after got %0d non-idle cycles want 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_back_to_back();
        test_irq();
        test_irq_during_stall();
        test_reset_in_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
